// File: rtl/route_pkg.sv
// Shared types for the route sequencer and the direction controller it drives.
package route_pkg;

  // Command codes understood by directioncontrol.
  typedef enum logic [2:0] {
    ACT_FOLLOW = 3'b000,
    ACT_LEFT   = 3'b001,
    ACT_RIGHT  = 3'b010,
    ACT_IDLE   = 3'b011,
    ACT_BACK   = 3'b100
  } action_t;

  // Per-crossing instruction stored in the route RAM.
  typedef enum logic [1:0] {
    STEP_STRAIGHT = 2'b00,
    STEP_LEFT     = 2'b01,
    STEP_RIGHT    = 2'b10,
    STEP_STOP     = 2'b11
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_PASS,
    ST_TURN_OUT,
    ST_TURN_IN,
    ST_BACKUP,
    ST_DONE,
    ST_FAULT
  } state_t;

  // Action presented to directioncontrol while in a given state.
  function automatic action_t state_action(input state_t s, input logic turn_right);
    case (s)
      ST_FOLLOW, ST_PASS:      return ACT_FOLLOW;
      ST_TURN_OUT, ST_TURN_IN: return turn_right ? ACT_RIGHT : ACT_LEFT;
      ST_BACKUP:               return ACT_BACK;
      default:                 return ACT_IDLE;
    endcase
  endfunction

  function automatic logic state_busy(input state_t s);
    return (s == ST_FOLLOW) || (s == ST_PASS) || (s == ST_TURN_OUT) ||
           (s == ST_TURN_IN) || (s == ST_BACKUP);
  endfunction

endpackage

// File: rtl/line_sensor_filter.sv
// Two-flop synchronizer for the raw line sensors plus crossing (111) and
// line-loss (000) debounce. Sync bit order is {l, m, r}.
module line_sensor_filter #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_l,
  input  logic       sensor_m,
  input  logic       sensor_r,
  output logic [2:0] sync,
  output logic       cross_ok,
  output logic       lost_ok
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYC);

  logic [1:0][2:0] sync_pipe;
  logic [CW-1:0]   cross_cnt;
  logic [CW-1:0]   lost_cnt;

  assign sync     = sync_pipe[1];
  assign cross_ok = (cross_cnt == DEB_MAX);
  assign lost_ok  = (lost_cnt == DEB_MAX);

  // Metastability guard: raw sensors shift through two flops.
  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], {sensor_l, sensor_m, sensor_r}};
  end

  // Saturating run-length counters; any other pattern breaks both runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cross_cnt <= '0;
      lost_cnt  <= '0;
    end else begin
      case (sync)
        3'b111: begin
          cross_cnt <= (cross_cnt == DEB_MAX) ? cross_cnt : cross_cnt + 1'b1;
          lost_cnt  <= '0;
        end
        3'b000: begin
          lost_cnt  <= (lost_cnt == DEB_MAX) ? lost_cnt : lost_cnt + 1'b1;
          cross_cnt <= '0;
        end
        default: begin
          cross_cnt <= '0;
          lost_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/route_sequencer.sv
// Mission controller: follows the line, executes one programmed step per
// crossing, backs up on line loss and reports done/fault. Outputs are
// registered from the next state so they move on the same edge as the state.
module route_sequencer
  import route_pkg::*;
#(
  parameter int ROUTE_DEPTH      = 16,
  parameter int DEBOUNCE_CYC     = 4,
  parameter int TURN_MIN_CYC     = 1000,
  parameter int TURN_TIMEOUT_CYC = 200000,
  localparam int AW = $clog2(ROUTE_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sensor_l,
  input  logic          sensor_m,
  input  logic          sensor_r,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   route_len,
  input  logic          route_wr_en,
  input  logic [AW-1:0] route_wr_addr,
  input  logic [1:0]    route_wr_data,
  output logic [2:0]    input_action,
  output logic [AW:0]   step_idx,
  output logic          busy,
  output logic          done,
  output logic          fault
);
  localparam int TW = $clog2(TURN_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MIN = TW'(TURN_MIN_CYC);
  localparam logic [TW-1:0] T_TMO = TW'(TURN_TIMEOUT_CYC - 1);

  logic [2:0]    sync;
  logic          cross_ok, lost_ok;
  logic [1:0]    route_ram [ROUTE_DEPTH];
  step_t         cur_step;
  state_t        state, nxt_state;
  logic          turn_right, nxt_right;
  logic [AW:0]   nxt_step, step_inc;
  logic [TW-1:0] timer;
  logic          tmo, timed_entry;

  line_sensor_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .sensor_l (sensor_l),
    .sensor_m (sensor_m),
    .sensor_r (sensor_r),
    .sync     (sync),
    .cross_ok (cross_ok),
    .lost_ok  (lost_ok)
  );

  // Route RAM: not reset so a program survives reset; frozen while running.
  always_ff @(posedge clk) begin
    if (route_wr_en && !busy) route_ram[route_wr_addr] <= route_wr_data;
  end

  assign cur_step = step_t'(route_ram[step_idx[AW-1:0]]);
  assign step_inc = (step_idx < route_len) ? step_idx + 1'b1 : step_idx;
  assign tmo      = (timer == T_TMO);

  // Next-state decode; abort outranks timeout, which outranks sensor events.
  always_comb begin
    nxt_state = state;
    nxt_step  = step_idx;
    nxt_right = turn_right;
    if (abort) begin
      nxt_state = ST_IDLE;
      nxt_step  = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) begin
            nxt_state = (route_len != '0) ? ST_FOLLOW : ST_DONE;
            nxt_step  = '0;
          end
        end
        ST_FOLLOW: begin
          if (cross_ok) begin
            if (step_idx >= route_len) nxt_state = ST_DONE;
            else begin
              case (cur_step)
                STEP_STRAIGHT: nxt_state = ST_PASS;
                STEP_LEFT:  begin nxt_state = ST_TURN_OUT; nxt_right = 1'b0; end
                STEP_RIGHT: begin nxt_state = ST_TURN_OUT; nxt_right = 1'b1; end
                default:       nxt_state = ST_DONE;
              endcase
            end
          end else if (lost_ok) begin
            nxt_state = ST_BACKUP;
          end
        end
        ST_PASS: begin
          if (sync != 3'b111) begin
            nxt_state = ST_FOLLOW;
            nxt_step  = step_inc;
          end
        end
        ST_TURN_OUT: begin
          if (tmo)          nxt_state = ST_FAULT;
          else if (!sync[1]) nxt_state = ST_TURN_IN;
        end
        ST_TURN_IN: begin
          if (tmo) nxt_state = ST_FAULT;
          else if (sync[1] && timer >= T_MIN) begin
            nxt_state = ST_FOLLOW;
            nxt_step  = step_inc;
          end
        end
        ST_BACKUP: begin
          if (tmo)        nxt_state = ST_FAULT;
          else if (|sync) nxt_state = ST_FOLLOW;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  // A turn (TURN_OUT+TURN_IN) or a backup starts a fresh timer on entry.
  assign timed_entry = (nxt_state == ST_TURN_OUT && state != ST_TURN_OUT) ||
                       (nxt_state == ST_BACKUP && state != ST_BACKUP);

  // Shared turn/backup timer; idle at zero outside timed states.
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else if (timed_entry || !(nxt_state inside {ST_TURN_OUT, ST_TURN_IN, ST_BACKUP}))
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  // FSM state and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      turn_right   <= 1'b0;
      step_idx     <= '0;
      input_action <= ACT_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= nxt_state;
      turn_right   <= nxt_right;
      step_idx     <= nxt_step;
      input_action <= state_action(nxt_state, nxt_right);
      busy         <= state_busy(nxt_state);
      done         <= (nxt_state == ST_DONE);
      fault        <= (nxt_state == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Directed scenarios for route_sequencer. Stimulus pushes the expected output
// snapshot (and the cycle it should appear on) into a queue; the monitor pops
// one entry every time the DUT's output bundle changes.
module tb_route_sequencer;
  localparam int TMO = 3000;
  localparam int MIN = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_l = 1'b0, sensor_m = 1'b1, sensor_r = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [4:0] route_len = '0;
  logic       route_wr_en = 1'b0;
  logic [3:0] route_wr_addr = '0;
  logic [1:0] route_wr_data = '0;
  logic [2:0] input_action;
  logic [4:0] step_idx;
  logic       busy, done, fault;

  route_sequencer #(
    .ROUTE_DEPTH(16), .DEBOUNCE_CYC(4), .TURN_MIN_CYC(MIN), .TURN_TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r),
    .start(start), .abort(abort), .route_len(route_len),
    .route_wr_en(route_wr_en), .route_wr_addr(route_wr_addr), .route_wr_data(route_wr_data),
    .input_action(input_action), .step_idx(step_idx),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [2:0] act;
    logic [4:0] step;
    logic       b, d, f;
    int         at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 0;
  bit   have_prev = 0;
  logic [10:0] prev;

  task automatic push(input string name, input logic [2:0] act, input int step,
                      input logic b, input logic d, input logic f, input int at);
    exp_t e;
    e.name = name; e.act = act; e.step = step[4:0];
    e.b = b; e.d = d; e.f = f; e.at = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic until_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drv(input logic [2:0] p);
    {sensor_l, sensor_m, sensor_r} = p;
  endtask

  task automatic wr(input int a, input logic [1:0] d);
    route_wr_en = 1'b1; route_wr_addr = a[3:0]; route_wr_data = d;
    tick(1);
    route_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input string name, input logic [2:0] act,
                             input logic b, input logic d);
    push(name, act, 0, b, d, 1'b0, cyc + 1);
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  // Monitor: every change of the output bundle consumes one expectation.
  always @(negedge clk) begin
    logic [10:0] cur;
    exp_t e;
    cur = {input_action, step_idx, busy, done, fault};
    if (mon_on && (!have_prev || cur !== prev)) begin
      have_prev = 1;
      prev = cur;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got act=%b step=%0d busy=%b done=%b fault=%b",
                 cyc, input_action, step_idx, busy, done, fault);
      end else begin
        e = q.pop_front();
        if (cur !== {e.act, e.step, e.b, e.d, e.f} || (e.at >= 0 && e.at != cyc)) begin
          bad++;
          $display("FAIL %s cyc=%0d got act=%b step=%0d busy=%b done=%b fault=%b, want cyc=%0d act=%b step=%0d busy=%b done=%b fault=%b",
                   e.name, cyc, input_action, step_idx, busy, done, fault,
                   e.at, e.act, e.step, e.b, e.d, e.f);
        end
      end
    end
  end

  initial begin
    int c, t;
    drv(3'b010);
    tick(3);
    push("reset_state", 3'b011, 0, 0, 0, 0, -1);
    mon_on = 1;
    tick(1);
    reset = 1'b0;

    // Route {LEFT, STRAIGHT, STOP}
    wr(0, 2'b01); wr(1, 2'b00); wr(2, 2'b11);
    route_len = 5'd3;
    tick(2);
    pulse_start("start_follow", 3'b000, 1, 0);
    tick(5);
    wr(2, 2'b00);                       // busy: must be ignored
    c = cyc;
    push("cross_left_latency", 3'b001, 0, 1, 0, 0, c + 7);
    drv(3'b111); tick(10); drv(3'b001); // leave the line -> TURN_IN
    t = c + 7;
    until_cyc(t + 500);
    push("turn_min_reacquire", 3'b000, 1, 1, 0, 0, t + MIN + 1);
    drv(3'b010);                        // early re-acquisition held until MIN
    tick(MIN);
    c = cyc;
    drv(3'b111); tick(10);
    push("straight_step", 3'b000, 2, 1, 0, 0, c + 13);
    drv(3'b010); tick(20);
    c = cyc;
    push("stop_done", 3'b011, 2, 0, 1, 0, c + 7);
    drv(3'b111); tick(10); drv(3'b010); tick(5);

    // Line loss: backup, recovery, then backup timeout
    pulse_start("restart_from_done", 3'b000, 1, 0);
    tick(10);
    c = cyc;
    push("lost_backup", 3'b100, 0, 1, 0, 0, c + 7);
    drv(3'b000); tick(15);
    c = cyc;
    push("backup_recover", 3'b000, 0, 1, 0, 0, c + 3);
    drv(3'b001); tick(10);
    c = cyc;
    push("lost_backup2", 3'b100, 0, 1, 0, 0, c + 7);
    push("backup_timeout", 3'b011, 0, 0, 0, 1, c + 7 + TMO);
    drv(3'b000);
    until_cyc(c + TMO + 20);
    drv(3'b010);

    // Empty route: start goes straight to DONE
    route_len = 5'd0;
    pulse_start("empty_route_done", 3'b011, 0, 1);
    tick(3);

    // RIGHT turn that never loses the middle sensor
    wr(0, 2'b10); route_len = 5'd1;
    pulse_start("start_right", 3'b000, 1, 0);
    tick(5);
    c = cyc;
    push("cross_right", 3'b010, 0, 1, 0, 0, c + 7);
    push("turn_timeout", 3'b011, 0, 0, 0, 1, c + 7 + TMO);
    drv(3'b111); tick(10); drv(3'b010);
    until_cyc(c + TMO + 20);

    // Abort during TURN_IN
    wr(0, 2'b01);
    pulse_start("start_from_fault", 3'b000, 1, 0);
    tick(5);
    c = cyc;
    push("cross_left2", 3'b001, 0, 1, 0, 0, c + 7);
    drv(3'b111); tick(10); drv(3'b000); tick(10);
    push("abort_turn_in", 3'b011, 0, 0, 0, 0, cyc + 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    drv(3'b010); tick(5);

    // step_idx == route_len at a crossing, then reset mid-FOLLOW
    wr(0, 2'b00);
    pulse_start("start_len1", 3'b000, 1, 0);
    tick(5);
    c = cyc;
    drv(3'b111); tick(10);
    push("len1_step", 3'b000, 1, 1, 0, 0, c + 13);
    drv(3'b010); tick(20);
    c = cyc;
    push("end_of_route_done", 3'b011, 1, 0, 1, 0, c + 7);
    drv(3'b111); tick(10); drv(3'b010); tick(5);
    pulse_start("start_again", 3'b000, 1, 0);
    tick(5);
    c = cyc;
    drv(3'b111); tick(10);
    push("len1_step2", 3'b000, 1, 1, 0, 0, c + 13);
    drv(3'b010); tick(20);
    push("reset_mid_follow", 3'b011, 0, 0, 0, 0, cyc + 1);
    reset = 1'b1; tick(2); reset = 1'b0;
    tick(10);

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s never observed, want act=%b step=%0d at cyc=%0d", e.name, e.act, e.step, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
